// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and FSM state type for the sequential ALU/MDU
package alu_pkg;

    localparam int M_SEL_BIT = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SRA  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_mdu_seq_base.sv
// rtl/alu_mdu_seq_base.sv - combinational base-op datapath (add/sub, compares, logic, shifts)
module alu_base
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SUB:  result = a - b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - multi-cycle ALU with radix-2 iterative multiply/divide behind valid/ready
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN),
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_t            state, state_next;
    logic [CNTW-1:0]   cnt;
    logic [XLEN-1:0]   mag_b, hi, lo;
    logic [2:0]        m_op;
    logic              neg;

    logic              accept, is_m, sa, sb, neg_a, neg_b, neg_in;
    logic              div_zero, div_ovf, fast;
    logic [2:0]        mop_in;
    logic [XLEN-1:0]   abs_a, abs_b, fast_res, base_res;

    assign accept = in_valid && (state == S_IDLE);
    assign is_m   = op[M_SEL_BIT];
    assign mop_in = op[2:0];

    alu_base #(.XLEN(XLEN), .SHW(SHW)) u_base (
        .op     (op[3:0]),
        .a      (a),
        .b      (b),
        .result (base_res)
    );

    // Operands are reduced to magnitudes; a single sign flag restores the sign at the end.
    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        case (mop_in)
            M_MULH, M_DIV, M_REM: begin sa = 1'b1; sb = 1'b1; end
            M_MULHSU:             sa = 1'b1;
            default:              ;
        endcase
    end

    assign neg_a  = sa & a[XLEN-1];
    assign neg_b  = sb & b[XLEN-1];
    assign abs_a  = neg_a ? -a : a;
    assign abs_b  = neg_b ? -b : b;
    assign neg_in = (mop_in == M_REM) ? neg_a : (neg_a ^ neg_b);

    assign div_zero = mop_in[2] && (b == '0);
    assign div_ovf  = (mop_in == M_DIV || mop_in == M_REM) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign fast     = is_m && (div_zero || div_ovf);

    always_comb begin
        if (div_zero) fast_res = mop_in[1] ? a : '1;
        else          fast_res = mop_in[1] ? '0 : a;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]     mul_sum, div_shift, div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo;

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign div_ge    = !div_trial[XLEN];

    always_comb begin
        if (m_op[2]) begin
            step_hi = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, final_res;

    assign prod_fix = neg ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign q_fix    = neg ? -step_lo : step_lo;
    assign r_fix    = neg ? -step_hi : step_hi;

    always_comb begin
        if (m_op[2])             final_res = m_op[1] ? r_fix : q_fix;
        else if (m_op == M_MUL)  final_res = prod_fix[XLEN-1:0];
        else                     final_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (is_m && !fast) ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (cnt == CNTW'(1)) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            mag_b  <= '0;
            m_op   <= '0;
            neg    <= 1'b0;
        end else if (accept) begin
            m_op <= mop_in;
            neg  <= neg_in;
            if (!is_m) begin
                result <= base_res;
            end else if (fast) begin
                result <= fast_res;
            end else begin
                hi    <= '0;
                lo    <= abs_a;
                mag_b <= abs_b;
                cnt   <= CNTW'(XLEN);
            end
        end else if (state == S_BUSY) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) result <= final_res;
        end
    end

endmodule
